// File: rtl/addr_sequencer.sv
// Address sequencer: steps an address up or down at one of NUM_SPEEDS rates,
// with debounced buttons for speed, pause/resume and manual single-stepping.
module addr_sequencer #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned ADDR_MAX      = 2**ADDR_W-1,
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned NUM_SPEEDS    = 5,
  parameter int unsigned DEFAULT_SPEED = 2,
  parameter int unsigned DEB_CYCLES    = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pause,
  input  logic                          speedup,
  input  logic                          speeddown,
  input  logic                          step_fwd,
  input  logic                          step_back,
  input  logic                          dir,
  output logic [ADDR_W-1:0]             addr,
  output logic                          paused,
  output logic [$clog2(NUM_SPEEDS)-1:0] speed_level,
  output logic                          tick,
  output logic                          wrap
);

  localparam int unsigned     SPD_W   = $clog2(NUM_SPEEDS);
  localparam longint unsigned P_MAX   = 64'(CLK_HZ) << DEFAULT_SPEED;
  localparam int unsigned     CNT_W   = (P_MAX > 1) ? $clog2(P_MAX) : 1;
  localparam int unsigned     DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned     NUM_BTN = 5;

  localparam int unsigned BTN_PAUSE = 0;
  localparam int unsigned BTN_UP    = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_FWD   = 3;
  localparam int unsigned BTN_BACK  = 4;

  // Terminal count for speed level k; the period never drops below one cycle.
  function automatic logic [CNT_W-1:0] period_m1(input int k);
    longint unsigned p;
    p = P_MAX >> k;
    if (p == 0) p = 1;
    return CNT_W'(p - 1);
  endfunction

  logic [NUM_BTN-1:0]            btn_raw;
  logic [NUM_BTN-1:0]            btn_meta_q, btn_sync_q;
  logic [NUM_BTN-1:0]            btn_deb_q, btn_deb_d;
  logic [NUM_BTN-1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]            btn_rise;
  logic                          dir_meta_q, dir_sync_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d, term;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SPD_W-1:0]  speed_q, speed_d;
  logic              paused_q, paused_d;
  logic              tick_q, tick_d, wrap_q, wrap_d;
  logic              move, move_up;
  logic              pause_evt, up_evt, down_evt, fwd_evt, back_evt;

  assign btn_raw = {step_back, step_fwd, speeddown, speedup, pause};

  // The debouncer counts consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    btn_deb_d = btn_deb_q;
    btn_rise  = '0;
    deb_cnt_d = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (btn_sync_q[b] != btn_deb_q[b]) begin
        if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
          btn_deb_d[b] = btn_sync_q[b];
          btn_rise[b]  = btn_sync_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
        end
      end
    end
  end

  assign pause_evt = btn_rise[BTN_PAUSE];
  assign up_evt    = btn_rise[BTN_UP];
  assign down_evt  = btn_rise[BTN_DOWN];
  assign fwd_evt   = btn_rise[BTN_FWD];
  assign back_evt  = btn_rise[BTN_BACK];

  always_comb begin
    term = period_m1(0);
    for (int k = 1; k < NUM_SPEEDS; k++) begin
      if (speed_q == SPD_W'(k)) term = period_m1(k);
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    wrap_d   = 1'b0;
    move     = 1'b0;
    move_up  = 1'b0;

    if (!paused_q) begin
      if (cnt_q == term) begin
        cnt_d   = '0;
        move    = 1'b1;
        move_up = !dir_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (fwd_evt != back_evt) begin
      move    = 1'b1;
      move_up = fwd_evt;
    end

    // A saturated press changes nothing, so it does not restart the period.
    if (up_evt && !down_evt && speed_q != SPD_W'(NUM_SPEEDS - 1)) begin
      speed_d = speed_q + SPD_W'(1);
      cnt_d   = '0;
    end else if (down_evt && !up_evt && speed_q != '0) begin
      speed_d = speed_q - SPD_W'(1);
      cnt_d   = '0;
    end

    // Evaluated against the old paused_q, so a completing period still advances.
    if (pause_evt) paused_d = !paused_q;

    if (move) begin
      if (move_up) begin
        if (addr_q == ADDR_W'(ADDR_MAX)) begin
          addr_d = '0;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        if (addr_q == '0) begin
          addr_d = ADDR_W'(ADDR_MAX);
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end
    end
    tick_d = move;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_deb_q  <= '0;
      deb_cnt_q  <= '0;
      dir_meta_q <= 1'b0;
      dir_sync_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      speed_q    <= SPD_W'(DEFAULT_SPEED);
      paused_q   <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      btn_deb_q  <= btn_deb_d;
      deb_cnt_q  <= deb_cnt_d;
      dir_meta_q <= dir;
      dir_sync_q <= dir_meta_q;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      speed_q    <= speed_d;
      paused_q   <= paused_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
    end
  end

  assign addr        = addr_q;
  assign paused      = paused_q;
  assign speed_level = speed_q;
  assign tick        = tick_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Self-checking bench for addr_sequencer: directed scenarios, a table of paused-mode
// button vectors, and a random run compared cycle by cycle against a reference model.
module tb_addr_sequencer;

  localparam int ADDR_W        = 4;
  localparam int ADDR_MAX      = 9;
  localparam int CLK_HZ        = 16;
  localparam int NUM_SPEEDS    = 5;
  localparam int DEFAULT_SPEED = 2;
  localparam int DEB           = 4;
  localparam int P0            = CLK_HZ << DEFAULT_SPEED;

  localparam logic [4:0] B_PAUSE = 5'b00001;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_FWD   = 5'b01000;
  localparam logic [4:0] B_BACK  = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause = 1'b0, speedup = 1'b0, speeddown = 1'b0, step_fwd = 1'b0, step_back = 1'b0;
  logic dir = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              paused;
  logic [2:0]        speed_level;
  logic              tick, wrap;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  addr_sequencer #(
    .ADDR_W(ADDR_W), .ADDR_MAX(ADDR_MAX), .CLK_HZ(CLK_HZ),
    .NUM_SPEEDS(NUM_SPEEDS), .DEFAULT_SPEED(DEFAULT_SPEED), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .speedup(speedup), .speeddown(speeddown),
    .step_fwd(step_fwd), .step_back(step_back), .dir(dir), .addr(addr), .paused(paused),
    .speed_level(speed_level), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw inputs reach the debouncer two edges late; a button
  // level is accepted once the last DEB samples all disagree with it.
  int         m_addr, m_speed, m_elapsed;
  bit         m_paused, m_tick, m_wrap, m_dir1, m_dir2;
  bit [4:0]   m_raw1, m_raw2, m_level;
  bit [4:0]   m_hist [DEB];

  always @(posedge clk) begin : ref_model
    bit [4:0] s, ev;
    bit       d, adv, up, all_diff;
    int       p;
    if (!rst_n) begin
      m_addr = 0; m_speed = DEFAULT_SPEED; m_elapsed = 0;
      m_paused = 0; m_tick = 0; m_wrap = 0;
      m_dir1 = 0; m_dir2 = 0; m_raw1 = 0; m_raw2 = 0; m_level = 0;
      for (int i = 0; i < DEB; i++) m_hist[i] = 0;
    end else begin
      s = m_raw2;
      d = m_dir2;
      m_raw2 = m_raw1;
      m_raw1 = {step_back, step_fwd, speeddown, speedup, pause};
      m_dir2 = m_dir1;
      m_dir1 = dir;
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s;
      ev = 0;
      for (int b = 0; b < 5; b++) begin
        all_diff = 1;
        for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_level[b]) all_diff = 0;
        if (all_diff) begin
          m_level[b] = s[b];
          ev[b] = s[b];
        end
      end
      p = P0 >> m_speed;
      if (p < 1) p = 1;
      adv = 0;
      up = 0;
      if (!m_paused) begin
        m_elapsed++;
        if (m_elapsed == p) begin
          m_elapsed = 0;
          adv = 1;
          up = !d;
        end
      end else if (ev[3] != ev[4]) begin
        adv = 1;
        up = ev[3];
      end
      if (ev[1] && !ev[2] && m_speed < NUM_SPEEDS - 1) begin
        m_speed++;
        m_elapsed = 0;
      end else if (ev[2] && !ev[1] && m_speed > 0) begin
        m_speed--;
        m_elapsed = 0;
      end
      if (ev[0]) m_paused = !m_paused;
      m_wrap = 0;
      if (adv) begin
        if (up) begin
          m_wrap = (m_addr == ADDR_MAX);
          m_addr = (m_addr + 1) % (ADDR_MAX + 1);
        end else begin
          m_wrap = (m_addr == 0);
          m_addr = (m_addr + ADDR_MAX) % (ADDR_MAX + 1);
        end
      end
      m_tick = adv;
    end
  end

  always @(negedge clk) begin
    if (model_on)
      check("model", 32'({addr, paused, speed_level, tick, wrap}),
            32'({4'(m_addr), m_paused, 3'(m_speed), m_tick, m_wrap}));
  end

  task automatic set_btns(input logic [4:0] m);
    {step_back, step_fwd, speeddown, speedup, pause} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int rel,
                       output int ticks, output int wraps);
    ticks = 0;
    wraps = 0;
    set_btns(m);
    for (int i = 0; i < hold + rel; i++) begin
      @(negedge clk);
      if (i == hold - 1) set_btns(5'b0);
      ticks += int'(tick);
      wraps += int'(wrap);
    end
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < budget);
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n;
    int k;
    k = 0;
    do begin
      wait_tick(budget, n);
      k++;
    end while (int'(addr) != a && k < 12);
    check("reach_addr", 32'(addr), 32'(a));
  endtask

  typedef struct {
    logic [4:0] mask;
    logic       dir_v;
    int         hold;
    int         exp_addr;
    int         exp_speed;
    logic       exp_paused;
    int         exp_ticks;
    int         exp_wraps;
  } vec_t;

  vec_t vecs [15];
  int   hold_left [5];

  initial begin
    int       n, t, w;
    logic [4:0] bv;

    // Paused-mode vectors, starting from addr=1, speed 2, paused.
    vecs[0]  = '{B_BACK,         1'b0, 10, 0, 2, 1'b1, 1, 0};
    vecs[1]  = '{B_BACK,         1'b0, 10, 9, 2, 1'b1, 1, 1};
    vecs[2]  = '{B_FWD,          1'b0, 10, 0, 2, 1'b1, 1, 1};
    vecs[3]  = '{B_FWD,          1'b1, 10, 1, 2, 1'b1, 1, 0};
    vecs[4]  = '{B_FWD | B_BACK, 1'b0, 10, 1, 2, 1'b1, 0, 0};
    vecs[5]  = '{B_UP | B_DOWN,  1'b0, 10, 1, 2, 1'b1, 0, 0};
    vecs[6]  = '{B_FWD,          1'b0,  1, 1, 2, 1'b1, 0, 0};
    vecs[7]  = '{B_BACK,         1'b1,  3, 1, 2, 1'b1, 0, 0};
    vecs[8]  = '{B_BACK,         1'b1,  4, 0, 2, 1'b1, 1, 0};
    vecs[9]  = '{B_UP,           1'b0, 10, 0, 3, 1'b1, 0, 0};
    vecs[10] = '{B_UP,           1'b0, 10, 0, 4, 1'b1, 0, 0};
    vecs[11] = '{B_UP,           1'b0, 10, 0, 4, 1'b1, 0, 0};
    vecs[12] = '{B_DOWN,         1'b0, 10, 0, 3, 1'b1, 0, 0};
    vecs[13] = '{B_DOWN,         1'b0, 10, 0, 2, 1'b1, 0, 0};
    vecs[14] = '{B_PAUSE,        1'b0,  5, 0, 2, 1'b0, 0, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_speed", 32'(speed_level), 32'(DEFAULT_SPEED));
    check("rst_tick", 32'({tick, wrap}), 32'd0);
    rst_n = 1'b1;

    // Free run at the default speed: one word per 16 cycles, wrap only on 9->0.
    for (int i = 1; i <= 10; i++) begin
      wait_tick(40, n);
      check("run_interval", 32'(n), 32'd16);
      check("run_addr", 32'(addr), 32'(i % 10));
      check("run_wrap", 32'(wrap), 32'(i == 10));
    end

    // Speed up three times; the last press saturates.
    press(B_UP, 10, 10, t, w);
    check("speed_a", 32'(speed_level), 32'd3);
    press(B_UP, 10, 10, t, w);
    check("speed_b", 32'(speed_level), 32'd4);
    press(B_UP, 10, 10, t, w);
    check("speed_sat", 32'(speed_level), 32'd4);
    wait_tick(20, n);
    wait_tick(20, n);
    check("fast_interval", 32'(n), 32'd4);
    press(B_UP, 1, 20, t, w);
    check("glitch_speed", 32'(speed_level), 32'd4);

    // Count down from 0 wraps to ADDR_MAX.
    wait_addr(0, 10);
    dir = 1'b1;
    wait_tick(10, n);
    check("down_interval", 32'(n), 32'd4);
    check("down_wrap_addr", 32'(addr), 32'd9);
    check("down_wrap", 32'(wrap), 32'd1);
    wait_tick(10, n);
    check("down_addr8", 32'(addr), 32'd8);
    check("down_nowrap", 32'(wrap), 32'd0);
    wait_tick(10, n);
    check("down_addr7", 32'(addr), 32'd7);

    // Pause at 5, hold, step, then resume from the held count.
    dir = 1'b0;
    press(B_DOWN, 10, 10, t, w);
    press(B_DOWN, 10, 10, t, w);
    check("slow_speed", 32'(speed_level), 32'd2);
    wait_addr(5, 40);
    press(B_PAUSE, 10, 10, t, w);
    check("pause_ticks", 32'(t), 32'd0);
    check("pause_flag", 32'(paused), 32'd1);
    check("pause_addr", 32'(addr), 32'd5);
    t = 0;
    repeat (200) begin
      @(negedge clk);
      t += int'(tick);
    end
    check("frozen_ticks", 32'(t), 32'd0);
    check("frozen_addr", 32'(addr), 32'd5);
    press(B_FWD, 10, 10, t, w);
    check("fwd_addr", 32'(addr), 32'd6);
    check("fwd_ticks", 32'(t), 32'd1);
    press(B_BACK, 10, 10, t, w);
    check("back1_ticks", 32'(t), 32'd1);
    press(B_BACK, 10, 10, t, w);
    check("back2_addr", 32'(addr), 32'd4);
    check("back2_ticks", 32'(t), 32'd1);
    pause = 1'b1;
    n = 0;
    while (n < 60 && !tick) begin
      @(negedge clk);
      n++;
      if (n == 10) pause = 1'b0;
    end
    pause = 1'b0;
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_interval", 32'(n), 32'd16);
    check("resume_paused", 32'(paused), 32'd0);
    check("resume_addr", 32'(addr), 32'd5);
    repeat (12) @(negedge clk);

    // Reset mid-period while slow, paused, at addr 7.
    press(B_DOWN, 10, 10, t, w);
    press(B_DOWN, 10, 10, t, w);
    check("slowest_speed", 32'(speed_level), 32'd0);
    wait_addr(7, 80);
    press(B_PAUSE, 10, 10, t, w);
    check("pre_rst_state", 32'({addr, paused, speed_level}), 32'({4'd7, 1'b1, 3'd0}));
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_paused", 32'(paused), 32'd0);
    check("mid_rst_speed", 32'(speed_level), 32'd2);
    check("mid_rst_tick", 32'({tick, wrap}), 32'd0);
    rst_n = 1'b1;
    wait_tick(40, n);
    check("post_rst_interval", 32'(n), 32'd16);
    check("post_rst_addr", 32'(addr), 32'd1);

    // Table of paused-mode vectors.
    press(B_PAUSE, 10, 10, t, w);
    check("tbl_pause_ticks", 32'(t), 32'd0);
    check("tbl_pause_state", 32'({addr, paused}), 32'({4'd1, 1'b1}));
    for (int i = 0; i < 15; i++) begin
      dir = vecs[i].dir_v;
      press(vecs[i].mask, vecs[i].hold, 12, t, w);
      check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_speed", i), 32'(speed_level), 32'(vecs[i].exp_speed));
      check($sformatf("vec%0d_paused", i), 32'(paused), 32'(vecs[i].exp_paused));
      check($sformatf("vec%0d_ticks", i), 32'(t), 32'(vecs[i].exp_ticks));
      check($sformatf("vec%0d_wraps", i), 32'(w), 32'(vecs[i].exp_wraps));
    end

    // Random buttons, direction flips and occasional reset pulses.
    bv = '0;
    for (int b = 0; b < 5; b++) hold_left[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold_left[b] == 0) begin
          bv[b] = ($urandom_range(0, 2) == 0);
          hold_left[b] = bv[b] ? int'($urandom_range(1, 12)) : int'($urandom_range(2, 40));
        end else begin
          hold_left[b]--;
        end
      end
      set_btns(bv);
      if ($urandom_range(0, 99) == 0) dir = ~dir;
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    set_btns(5'b0);
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter ADDR_MAX, default 2**ADDR_W-1, last valid address (wrap point).
REQ-003 Parameter CLK_HZ, default 100_000_000, clk frequency.
REQ-004 Parameter NUM_SPEEDS, default 5, number of speed levels (>=2).
REQ-005 Parameter DEFAULT_SPEED, default 2, level after reset; that level gives 1 word/s.
REQ-006 Parameter DEB_CYCLES, default 1_000_000, button debounce stable time in cycles.
REQ-007 clk  input  1  system clock; all logic on posedge.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 pause, speedup, speeddown, step_fwd, step_back  input  1 each  raw buttons, high when pressed.
REQ-010 dir  input  1  level switch: 0 = count up, 1 = count down.
REQ-011 addr  output  ADDR_W  current address.
REQ-012 paused  output  1  high while sequencing is frozen.
REQ-013 speed_level  output  $clog2(NUM_SPEEDS)  current speed level.
REQ-014 tick  output  1  one-cycle pulse in the cycle addr takes a new value.
REQ-015 wrap  output  1  one-cycle pulse coincident with tick when addr wraps.

Function
REQ-016 Each button SHALL pass through a 2-FF synchroniser, then a debouncer accepting a new level only after DEB_CYCLES consecutive identical synchronised samples.
REQ-017 A button event SHALL be a single-cycle pulse on the debounced rising edge; holding a button SHALL produce exactly one event.
REQ-018 dir SHALL be 2-FF synchronised, not debounced.
REQ-019 Level k SHALL have period P(k) = (CLK_HZ << DEFAULT_SPEED) >> k cycles per word; P(k) computed at elaboration, minimum 1.
REQ-020 speedup event SHALL increment speed_level, saturating at NUM_SPEEDS-1; speeddown SHALL decrement, saturating at 0.
REQ-021 speedup and speeddown events in the same cycle SHALL both be ignored.
REQ-022 Any accepted speed change SHALL clear the period counter to 0.
REQ-023 pause event SHALL toggle paused.
REQ-024 While !paused, the counter SHALL increment each cycle; at P(level)-1 it SHALL clear, addr SHALL advance one step per dir on the next edge, tick SHALL assert for that cycle.
REQ-025 While paused, the counter SHALL hold its value; auto-advance SHALL not occur.
REQ-026 While paused, step_fwd SHALL advance addr +1 and step_back -1 (ignoring dir), each with a tick pulse; both in the same cycle SHALL be ignored.
REQ-027 Step events while !paused SHALL be ignored.
REQ-028 Up from ADDR_MAX SHALL wrap to 0; down from 0 SHALL wrap to ADDR_MAX; wrap SHALL pulse with tick on both auto and manual moves.
REQ-029 Pause event coinciding with a period completion: the advance SHALL complete, then paused SHALL be 1.
REQ-030 tick and wrap SHALL be registered, never asserted more than one cycle per move.

Reset
REQ-031 When rst_n=0 at a clk edge: addr=0, paused=0, speed_level=DEFAULT_SPEED, counter=0, tick=0, wrap=0, synchronisers and debouncers cleared to released state.
REQ-032 Reset mid-period or mid-debounce SHALL discard the partial count; no event or tick SHALL be generated by reset release.

Verification
REQ-033 Bench params: ADDR_W=4, ADDR_MAX=9, CLK_HZ=16, NUM_SPEEDS=5, DEFAULT_SPEED=2, DEB_CYCLES=4 (P = 64,32,16,8,4).
REQ-034 Release reset, no buttons -> tick every 16 cycles; addr 0,1,...,9,0 with wrap pulsing on 9->0 only.
REQ-035 Press speedup 3 times (each held 10 cycles, 10 released) -> speed_level 3 then 4 then 4 (saturated); tick interval 4 cycles; 1-cycle glitch pulse on speedup -> no change.
REQ-036 dir=1 from addr=0 -> next tick gives addr=9 with wrap=1; then 8, 7.
REQ-037 Press pause at addr=5 -> addr frozen 200 cycles; step_fwd -> 6, step_back twice -> 4, each one tick; press pause again -> resumes from held counter value.
REQ-038 Assert rst_n=0 mid-period at speed_level=0, addr=7, paused=1 -> next cycle addr=0, paused=0, speed_level=2; first tick 16 cycles after release.
